shift_tx_ctrl: RTL and testbench

Sequencing controller for the 8-bit right-shift register datapath. It accepts a byte over a valid/ready handshake, parallel-loads it into the register, then shifts it out LSB-first on a serial line, holding each bit for a programmable number of clock cycles. It sits between a byte producer (e.g. keypad or counter logic) and a serial output pin or LED, and owns all S_L / s_in sequencing of the shift register.

---
 rtl/shift_tx_pkg.sv | 6 +
 rtl/shift_reg_core.sv | 13 +
 rtl/shift_tx_ctrl.sv | 118 +++++++++++
 tb/tb_shift_tx_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/shift_tx_pkg.sv
// shift_tx_pkg: shared types and constants for the serial shift transmitter.
package shift_tx_pkg;
    localparam int DATA_W = 8;
    localparam logic SER_IDLE = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
endpackage

// File: rtl/shift_reg_core.sv
// shift_reg_core: 8-bit register, S_L=1 parallel-loads p_in, S_L=0 shifts right with s_in into the MSB.
module shift_reg_core
    import shift_tx_pkg::*;
(
    input  logic              clk,
    input  logic              S_L,
    input  logic              s_in,
    input  logic [DATA_W-1:0] p_in,
    output logic [DATA_W-1:0] Q
);
    always_ff @(posedge clk)
        Q <= S_L ? p_in : {s_in, Q[DATA_W-1:1]};
endmodule

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: accepts a byte, shifts it out LSB-first holding each bit DIV cycles.
// Optional even-parity bit after bit 7 when SHIFT_TX_CTRL_PARITY_EN is defined.
module shift_tx_ctrl
    import shift_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);
    state_t            r_state;
    logic [7:0]        r_div;
    logic [2:0]        r_cnt;
    logic              r_ready;
    logic              r_ser;
    logic              r_busy;
    logic              r_done;
`ifdef SHIFT_TX_CTRL_PARITY_EN
    logic              r_par;
`endif
    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] w_pin;
    logic              w_sl;
    logic              w_last;
    logic              w_accept;
    logic              w_shift;

    assign w_last   = r_div == 8'(DIV - 1);
    assign w_accept = r_state == IDLE && tx_valid && r_ready;
    assign w_shift  = r_state == SHIFT && w_last;
    // No enable on the datapath: holding means reloading Q; reset forces a load of zero.
    assign w_sl  = rst || !w_shift;
    assign w_pin = rst ? '0 : w_accept ? tx_data : w_q;

    shift_reg_core u_core (
        .clk  (clk),
        .S_L  (w_sl),
        .s_in (1'b1),
        .p_in (w_pin),
        .Q    (w_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_ser   <= SER_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= !w_accept;
                    r_busy  <= w_accept;
                    r_ser   <= w_accept ? tx_data[0] : SER_IDLE;
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_div   <= '0;
                        r_cnt   <= '0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
                        r_par   <= ^tx_data;
`endif
                    end
                end
                SHIFT: begin
                    r_div <= w_last ? 8'd0 : r_div + 8'd1;
                    if (w_last) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
`ifdef SHIFT_TX_CTRL_PARITY_EN
                            r_state <= PAR;
                            r_ser   <= r_par;
`else
                            r_state <= DONE;
                            r_ser   <= SER_IDLE;
                            r_done  <= 1'b1;
`endif
                        end else
                            r_ser <= w_q[1];
                    end
                end
`ifdef SHIFT_TX_CTRL_PARITY_EN
                PAR: begin
                    r_div <= w_last ? 8'd0 : r_div + 8'd1;
                    if (w_last) begin
                        r_state <= DONE;
                        r_ser   <= SER_IDLE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign ser_out  = r_ser;
    assign busy     = r_busy;
    assign done     = r_done;
endmodule

// File: tb/tb_shift_tx_ctrl.sv
// tb_shift_tx_ctrl: directed bench for shift_tx_ctrl at DIV=4 and DIV=1.
module tb_shift_tx_ctrl;
`ifdef SHIFT_TX_CTRL_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d4_data = '0, d1_data = '0;
    logic       d4_valid = 1'b0, d1_valid = 1'b0;
    logic       rdy4, ser4, busy4, done4;
    logic       rdy1, ser1, busy1, done1;
    int         n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    shift_tx_ctrl #(.DIV(4)) dut4 (
        .clk(clk), .rst(rst), .tx_data(d4_data), .tx_valid(d4_valid),
        .tx_ready(rdy4), .ser_out(ser4), .busy(busy4), .done(done4)
    );
    shift_tx_ctrl #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(d1_data), .tx_valid(d1_valid),
        .tx_ready(rdy1), .ser_out(ser1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts in the cycle after the accept edge; ends in the DONE cycle.
    task automatic frame(input bit sel, input logic [7:0] d, input int div);
        logic e;
        for (int b = 0; b < 8 + PB; b++)
            for (int c = 0; c < div; c++) begin
                e = (b < 8) ? d[b] : ^d;
                chk($sformatf("ser d=%h b=%0d c=%0d", d, b, c), {7'd0, sel ? ser1 : ser4}, {7'd0, e});
                chk($sformatf("busy d=%h b=%0d", d, b), {7'd0, sel ? busy1 : busy4}, 8'd1);
                chk($sformatf("nodone d=%h b=%0d", d, b), {7'd0, sel ? done1 : done4}, 8'd0);
                chk($sformatf("rdy0 d=%h b=%0d", d, b), {7'd0, sel ? rdy1 : rdy4}, 8'd0);
                tick();
            end
        chk($sformatf("done_pulse d=%h", d), {7'd0, sel ? done1 : done4}, 8'd1);
        chk($sformatf("done_busy d=%h", d), {7'd0, sel ? busy1 : busy4}, 8'd1);
        chk($sformatf("done_ser d=%h", d), {7'd0, sel ? ser1 : ser4}, 8'd1);
        chk($sformatf("done_rdy d=%h", d), {7'd0, sel ? rdy1 : rdy4}, 8'd0);
    endtask

    initial begin
        // reset, with tx_valid high on the same edges: reset wins
        d4_valid = 1'b1;
        d4_data  = 8'h55;
        tick();
        tick();
        chk("rst_rdy", {7'd0, rdy4}, 8'd0);
        chk("rst_ser", {7'd0, ser4}, 8'd1);
        chk("rst_busy", {7'd0, busy4}, 8'd0);
        chk("rst_done", {7'd0, done4}, 8'd0);
        chk("rst_reg", dut4.w_q, 8'h00);
        d4_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rel_rdy4", {7'd0, rdy4}, 8'd1);
        chk("rel_rdy1", {7'd0, rdy1}, 8'd1);
        chk("rel_busy", {7'd0, busy4}, 8'd0);
        // A5 at DIV=4, with 3C offered throughout the frame and ignored
        d4_data  = 8'hA5;
        d4_valid = 1'b1;
        tick();
        d4_data = 8'h3C;
        frame(1'b0, 8'hA5, 4);
        d4_valid = 1'b0;
        tick();
        chk("a5_idle_rdy", {7'd0, rdy4}, 8'd1);
        chk("a5_idle_busy", {7'd0, busy4}, 8'd0);
        chk("a5_idle_done", {7'd0, done4}, 8'd0);
        chk("a5_reg", dut4.w_q, 8'hFF);
        // back-to-back at DIV=1, tx_valid held high
        d1_data  = 8'h01;
        d1_valid = 1'b1;
        tick();
        d1_data = 8'h80;
        frame(1'b1, 8'h01, 1);
        tick();
        chk("b2b_idle_rdy", {7'd0, rdy1}, 8'd1);
        chk("b2b_idle_busy", {7'd0, busy1}, 8'd0);
        tick();
        frame(1'b1, 8'h80, 1);
        d1_valid = 1'b0;
        tick();
        chk("b2b_end_rdy", {7'd0, rdy1}, 8'd1);
        // reset during bit 3 of FF
        d4_data  = 8'hFF;
        d4_valid = 1'b1;
        tick();
        d4_valid = 1'b0;
        repeat (13) tick();
        chk("ff_bit3_busy", {7'd0, busy4}, 8'd1);
        rst = 1'b1;
        tick();
        chk("abort_ser", {7'd0, ser4}, 8'd1);
        chk("abort_busy", {7'd0, busy4}, 8'd0);
        chk("abort_done", {7'd0, done4}, 8'd0);
        chk("abort_rdy", {7'd0, rdy4}, 8'd0);
        chk("abort_reg", dut4.w_q, 8'h00);
        rst = 1'b0;
        tick();
        chk("abort_nodone", {7'd0, done4}, 8'd0);
        chk("abort_rel_rdy", {7'd0, rdy4}, 8'd1);
        d4_data  = 8'h0F;
        d4_valid = 1'b1;
        tick();
        d4_valid = 1'b0;
        frame(1'b0, 8'h0F, 4);
        tick();
        chk("0f_reg", dut4.w_q, 8'hFF);
        chk("0f_rdy", {7'd0, rdy4}, 8'd1);
        // all-zero byte at DIV=1 leaves the register all ones
        d1_data  = 8'h00;
        d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        frame(1'b1, 8'h00, 1);
        tick();
        chk("00_reg", dut1.w_q, 8'hFF);
        chk("00_done_clr", {7'd0, done1}, 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
